mips_main_ctrl: RTL and testbench
=================================

Name: mips_main_ctrl

Overview:
- Multicycle MIPS main control unit: Moore FSM that sequences every instruction through fetch, decode, execute, memory and writeback steps.
- Drives all datapath selects and write enables.
- Generates the 3-bit ALU operation code consumed directly by the ALU, so no separate ALU decoder stage sits between them.
- Memory steps wait on a ready handshake.

Parameters:
- USE_MEM_READY, 1, when 0 mem_ready is ignored and treated as constant 1.
- STATE_W, 4, state register width; must be at least 4.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instr[31:26], taken from the instruction register.
- funct  in  6  instr[5:0], taken from the instruction register.
- mem_ready  in  1  memory completed the current access this cycle.
- pc_write  out  1  unconditional PC load.
- branch  out  1  conditional PC load; the datapath ANDs it with ALU zero.
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  destination register select: 0=rt, 1=rd.
- mem_to_reg  out  1  writeback data select: 0=ALUOut, 1=MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0=PC, 1=A register.
- alu_src_b  out  2  ALU B select: 00=B register, 01=constant 4, 10=sign-extended immediate, 11=sign-extended immediate shifted left 2.
- pc_src  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- alu_ctl  out  3  ALU operation: ADD 010, SUB 110, AND 000, OR 001, SLT 111.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.

Behaviour:
- Reset:
  - On a rising edge with reset=1, state loads FETCH.
  - While reset=1, every output is forced to 0, except alu_ctl, which is 010.
  - A reset mid-instruction abandons the instruction; no partial write occurs after the reset edge.
- Outputs are combinational decodes of the state register, opcode and funct. Defaults: all enables 0, all selects 0, alu_ctl=010.
- States, their outputs, and next-state rules:
  - FETCH: alu_src_b=01, add. ir_write and pc_write equal mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE: alu_src_b=11, add (precomputes branch target). Next state by opcode:
    - lw 100011 / sw 101011 -> MEMADR
    - R-type 000000 -> RTYPEEX
    - beq 000100 -> BEQEX
    - j 000010 -> JEX
    - addi 001000 / slti 001010 -> IMMEX (only with the optional feature)
    - any other opcode -> pulse illegal_op, go to FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=10, add. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD: i_or_d=1. Holds until mem_ready=1, then goes to MEMWB.
  - MEMWB: mem_to_reg=1, reg_write=1, instr_done=1. Goes to FETCH.
  - MEMWR: i_or_d=1, mem_write=1 held until mem_ready=1, instr_done on the ready cycle. Goes to FETCH.
  - RTYPEEX:
    - alu_src_a=1, alu_src_b=00.
    - alu_ctl by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
    - Any other funct: illegal_op pulse, alu_ctl=010, next state FETCH (no writeback).
    - Valid funct: next state ALUWB.
  - ALUWB: reg_dst=1, reg_write=1, instr_done=1. Goes to FETCH.
  - BEQEX: alu_src_a=1, alu_src_b=00, alu_ctl=110, branch=1, pc_src=01, instr_done=1. Goes to FETCH.
  - JEX: pc_write=1, pc_src=10, instr_done=1. Goes to FETCH.
- Latency with mem_ready held at 1:
  - R-type, sw, addi, slti: 4 cycles.
  - lw: 5 cycles.
  - beq, j: 3 cycles.
  - Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Unused state encodings go to FETCH on the next edge, and all outputs stay at their defaults in those states.

Optional Feature:
- Macro: MIPS_CTRL_IMM_EN.
- Defined: adds states IMMEX and IMMWB.
  - IMMEX: alu_src_a=1, alu_src_b=10, alu_ctl=010 for addi or 111 for slti. Goes to IMMWB.
  - IMMWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. Goes to FETCH.
- Undefined: addi and slti are illegal opcodes (illegal_op pulse in DECODE, return to FETCH).

Decomposition:
- Package mips_ctrl_pkg holds:
  - ALU code constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT).
  - Opcode and funct constants.
  - State encoding constants FETCH=0 through IMMWB=11.
- One combinational sub-module, mips_alu_dec (funct -> alu_ctl plus a valid flag), instantiated once in RTYPEEX decoding.

Test Plan:
- Reset held for 2 cycles, then released, mem_ready=1, IR=lw: all enables 0 during reset; cycle sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 in cycle 5.
- R-type with funct 100010, then 101010: alu_ctl=110, then 111 in RTYPEEX; reg_dst=1 and reg_write=1 in the following cycle; instr_done pulses once per instruction.
- sw with mem_ready low for 3 cycles in MEMWR: mem_write stays 1 for 4 cycles; instr_done only on the ready cycle; then FETCH.
- beq: branch=1, alu_ctl=110, pc_src=01 in cycle 3. j: pc_write=1, pc_src=10 in cycle 3.
- Opcode 111111 and R-type funct 000111: illegal_op pulses exactly 1 cycle; reg_write never asserts; FSM returns to FETCH.
- With MIPS_CTRL_IMM_EN defined, slti: alu_src_b=10, alu_ctl=111, then reg_write=1 with reg_dst=0. With the macro undefined, the same opcode raises illegal_op.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared constants for the multicycle MIPS main control unit:
//               ALU codes, opcodes, functs and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] RTYPEEX = 4'd6;
    localparam logic [3:0] ALUWB   = 4'd7;
    localparam logic [3:0] BEQEX   = 4'd8;
    localparam logic [3:0] JEX     = 4'd9;
    localparam logic [3:0] IMMEX   = 4'd10;
    localparam logic [3:0] IMMWB   = 4'd11;

endpackage
`default_nettype wire

// File: rtl/mips_main_ctrl_alu_dec.sv
`default_nettype none
// ============================================================================
// Module      : mips_alu_dec
// Description : R-type funct to 3-bit ALU operation decode with valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_alu_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctl,
    output logic       valid
);

    always_comb begin
        alu_ctl = ALU_ADD;
        valid   = 1'b1;
        case (funct)
            FN_ADD:  alu_ctl = ALU_ADD;
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_SLT:  alu_ctl = ALU_SLT;
            default: valid   = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_main_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_main_ctrl
// Description : Multicycle MIPS main control FSM driving all datapath selects,
//               enables and the ALU operation code. Build macro
//               MIPS_CTRL_IMM_EN adds addi/slti support (IMMEX/IMMWB).
// Revision    : 1.0 - initial release
// ============================================================================
module mips_main_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int USE_MEM_READY = 1,
    parameter int STATE_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_ctl,
    output logic       illegal_op,
    output logic       instr_done
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic               w_ready;
    logic [2:0]         w_rtype_alu_ctl;
    logic               w_funct_valid;
    logic               w_op_legal;

    assign w_ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    mips_alu_dec u_alu_dec (
        .funct   (funct),
        .alu_ctl (w_rtype_alu_ctl),
        .valid   (w_funct_valid)
    );

    always_comb begin
        case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: w_op_legal = 1'b1;
`ifdef MIPS_CTRL_IMM_EN
            OP_ADDI, OP_SLTI:                     w_op_legal = 1'b1;
`endif
            default:                              w_op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= STATE_W'(FETCH);
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = STATE_W'(FETCH);
        case (r_state)
            STATE_W'(FETCH):   w_next_state = w_ready ? STATE_W'(DECODE) : STATE_W'(FETCH);
            STATE_W'(DECODE): begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = STATE_W'(MEMADR);
                    OP_RTYPE:     w_next_state = STATE_W'(RTYPEEX);
                    OP_BEQ:       w_next_state = STATE_W'(BEQEX);
                    OP_J:         w_next_state = STATE_W'(JEX);
`ifdef MIPS_CTRL_IMM_EN
                    OP_ADDI, OP_SLTI: w_next_state = STATE_W'(IMMEX);
`endif
                    default:      w_next_state = STATE_W'(FETCH);
                endcase
            end
            STATE_W'(MEMADR):  w_next_state = (opcode == OP_LW) ? STATE_W'(MEMRD) : STATE_W'(MEMWR);
            STATE_W'(MEMRD):   w_next_state = w_ready ? STATE_W'(MEMWB) : STATE_W'(MEMRD);
            STATE_W'(MEMWR):   w_next_state = w_ready ? STATE_W'(FETCH) : STATE_W'(MEMWR);
            STATE_W'(RTYPEEX): w_next_state = w_funct_valid ? STATE_W'(ALUWB) : STATE_W'(FETCH);
`ifdef MIPS_CTRL_IMM_EN
            STATE_W'(IMMEX):   w_next_state = STATE_W'(IMMWB);
`endif
            default:           w_next_state = STATE_W'(FETCH);
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        i_or_d     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_ctl    = ALU_ADD;
        illegal_op = 1'b0;
        instr_done = 1'b0;
        case (r_state)
            STATE_W'(FETCH): begin
                alu_src_b = 2'b01;
                ir_write  = w_ready;
                pc_write  = w_ready;
            end
            STATE_W'(DECODE): begin
                alu_src_b  = 2'b11;
                illegal_op = ~w_op_legal;
            end
            STATE_W'(MEMADR): begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            STATE_W'(MEMRD): i_or_d = 1'b1;
            STATE_W'(MEMWB): begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            STATE_W'(MEMWR): begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                instr_done = w_ready;
            end
            STATE_W'(RTYPEEX): begin
                alu_src_a  = 1'b1;
                alu_ctl    = w_rtype_alu_ctl;
                illegal_op = ~w_funct_valid;
            end
            STATE_W'(ALUWB): begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            STATE_W'(BEQEX): begin
                alu_src_a  = 1'b1;
                alu_ctl    = ALU_SUB;
                branch     = 1'b1;
                pc_src     = 2'b01;
                instr_done = 1'b1;
            end
            STATE_W'(JEX): begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
            end
`ifdef MIPS_CTRL_IMM_EN
            STATE_W'(IMMEX): begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctl   = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            STATE_W'(IMMWB): begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
        // Reset overrides the state decode so nothing writes during reset.
        if (reset) begin
            pc_write   = 1'b0;
            branch     = 1'b0;
            i_or_d     = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_src     = 2'b00;
            alu_ctl    = ALU_ADD;
            illegal_op = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_main_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_main_ctrl
// Description : Directed scoreboard bench for mips_main_ctrl; expected output
//               vectors are queued per cycle and compared at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_main_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write, branch, i_or_d, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, illegal_op, instr_done;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctl;

    int checks = 0;
    int errors = 0;
    logic [17:0] sb_q[$];

    localparam logic [17:0] c_rst_vec = {9'b0, 2'b00, 2'b00, 3'b010, 2'b00};

    // Spec state numbering: F=0 D=1 MA=2 MR=3 MWB=4 MW=5 RX=6 AWB=7 BX=8 JX=9 IX=10 IWB=11
    localparam logic [3:0] c_f = 4'd0, c_d = 4'd1, c_ma = 4'd2, c_mr = 4'd3, c_mwb = 4'd4;
    localparam logic [3:0] c_mw = 4'd5, c_rx = 4'd6, c_awb = 4'd7, c_bx = 4'd8, c_jx = 4'd9;
    localparam logic [3:0] c_ix = 4'd10, c_iwb = 4'd11;

    always #5 clk = ~clk;

    mips_main_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .branch     (branch),
        .i_or_d     (i_or_d),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_ctl    (alu_ctl),
        .illegal_op (illegal_op),
        .instr_done (instr_done)
    );

    wire [17:0] w_obs = {pc_write, branch, i_or_d, mem_write, ir_write, reg_dst,
                         mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
                         alu_ctl, illegal_op, instr_done};

    // Output table per named state, written from the state descriptions.
    function automatic logic [17:0] exp_out(input logic [3:0] st, input logic [5:0] op,
                                            input logic [5:0] fn, input logic rdy);
        logic pw, br, iod, mw, irw, rd, m2r, rw, asa, ill, done;
        logic [1:0] asb, pcs;
        logic [2:0] ac;
        {pw, br, iod, mw, irw, rd, m2r, rw, asa, ill, done} = '0;
        asb = 2'b00; pcs = 2'b00; ac = 3'b010;
        case (st)
            4'd0: begin asb = 2'b01; irw = rdy; pw = rdy; end
            4'd1: begin
                asb = 2'b11;
                ill = !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                        op == 6'b000100 || op == 6'b000010
`ifdef MIPS_CTRL_IMM_EN
                        || op == 6'b001000 || op == 6'b001010
`endif
                       );
            end
            4'd2: begin asa = 1'b1; asb = 2'b10; end
            4'd3: iod = 1'b1;
            4'd4: begin m2r = 1'b1; rw = 1'b1; done = 1'b1; end
            4'd5: begin iod = 1'b1; mw = 1'b1; done = rdy; end
            4'd6: begin
                asa = 1'b1;
                case (fn)
                    6'b100000: ac = 3'b010;
                    6'b100010: ac = 3'b110;
                    6'b100100: ac = 3'b000;
                    6'b100101: ac = 3'b001;
                    6'b101010: ac = 3'b111;
                    default:   ill = 1'b1;
                endcase
            end
            4'd7: begin rd = 1'b1; rw = 1'b1; done = 1'b1; end
            4'd8: begin asa = 1'b1; ac = 3'b110; br = 1'b1; pcs = 2'b01; done = 1'b1; end
            4'd9: begin pw = 1'b1; pcs = 2'b10; done = 1'b1; end
            4'd10: begin asa = 1'b1; asb = 2'b10; ac = (op == 6'b001010) ? 3'b111 : 3'b010; end
            4'd11: begin rw = 1'b1; done = 1'b1; end
            default: ;
        endcase
        return {pw, br, iod, mw, irw, rd, m2r, rw, asa, asb, pcs, ac, ill, done};
    endfunction

    // One clock: drive inputs, queue the expectation, compare at the falling edge.
    task automatic step(input logic rst_i, input logic [5:0] op, input logic [5:0] fn,
                        input logic rdy, input logic [3:0] st, input string tag);
        logic [17:0] exp_v;
        reset = rst_i; opcode = op; funct = fn; mem_ready = rdy;
        sb_q.push_back(rst_i ? c_rst_vec : exp_out(st, op, fn, rdy));
        @(negedge clk);
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            exp_v = sb_q.pop_front();
            assert (w_obs === exp_v) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b", tag, w_obs, exp_v);
            end
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] c_lw = 6'b100011, c_sw = 6'b101011, c_rt = 6'b000000;
    localparam logic [5:0] c_beq = 6'b000100, c_j = 6'b000010, c_slti = 6'b001010;

    initial begin
        reset = 1'b1; opcode = c_lw; funct = 6'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step(1, c_lw, 6'd0, 1, c_f, "reset0");
        step(1, c_lw, 6'd0, 1, c_f, "reset1");
        // lw, ready throughout
        step(0, c_lw, 6'd0, 1, c_f,   "lw_fetch");
        step(0, c_lw, 6'd0, 1, c_d,   "lw_decode");
        step(0, c_lw, 6'd0, 1, c_ma,  "lw_memadr");
        step(0, c_lw, 6'd0, 1, c_mr,  "lw_memrd");
        step(0, c_lw, 6'd0, 1, c_mwb, "lw_memwb");
        // R-type sub then slt
        step(0, c_rt, 6'b100010, 1, c_f,   "sub_fetch");
        step(0, c_rt, 6'b100010, 1, c_d,   "sub_decode");
        step(0, c_rt, 6'b100010, 1, c_rx,  "sub_ex");
        step(0, c_rt, 6'b100010, 1, c_awb, "sub_wb");
        step(0, c_rt, 6'b101010, 1, c_f,   "slt_fetch");
        step(0, c_rt, 6'b101010, 1, c_d,   "slt_decode");
        step(0, c_rt, 6'b101010, 1, c_rx,  "slt_ex");
        step(0, c_rt, 6'b101010, 1, c_awb, "slt_wb");
        // sw with three not-ready cycles in MEMWR
        step(0, c_sw, 6'd0, 1, c_f,  "sw_fetch");
        step(0, c_sw, 6'd0, 1, c_d,  "sw_decode");
        step(0, c_sw, 6'd0, 1, c_ma, "sw_memadr");
        step(0, c_sw, 6'd0, 0, c_mw, "sw_wait0");
        step(0, c_sw, 6'd0, 0, c_mw, "sw_wait1");
        step(0, c_sw, 6'd0, 0, c_mw, "sw_wait2");
        step(0, c_sw, 6'd0, 1, c_mw, "sw_ready");
        // beq with a fetch stall, then j
        step(0, c_beq, 6'd0, 0, c_f,  "beq_fetch_stall");
        step(0, c_beq, 6'd0, 1, c_f,  "beq_fetch");
        step(0, c_beq, 6'd0, 1, c_d,  "beq_decode");
        step(0, c_beq, 6'd0, 1, c_bx, "beq_ex");
        step(0, c_j, 6'd0, 1, c_f,  "j_fetch");
        step(0, c_j, 6'd0, 1, c_d,  "j_decode");
        step(0, c_j, 6'd0, 1, c_jx, "j_ex");
        // lw with a read stall
        step(0, c_lw, 6'd0, 1, c_f,   "lw2_fetch");
        step(0, c_lw, 6'd0, 1, c_d,   "lw2_decode");
        step(0, c_lw, 6'd0, 1, c_ma,  "lw2_memadr");
        step(0, c_lw, 6'd0, 0, c_mr,  "lw2_rd_wait");
        step(0, c_lw, 6'd0, 1, c_mr,  "lw2_rd_ready");
        step(0, c_lw, 6'd0, 1, c_mwb, "lw2_memwb");
        // illegal opcode and illegal funct
        step(0, 6'b111111, 6'd0, 1, c_f, "badop_fetch");
        step(0, 6'b111111, 6'd0, 1, c_d, "badop_decode");
        step(0, c_rt, 6'b000111, 1, c_f,  "badfn_fetch");
        step(0, c_rt, 6'b000111, 1, c_d,  "badfn_decode");
        step(0, c_rt, 6'b000111, 1, c_rx, "badfn_ex");
        // slti
        step(0, c_slti, 6'd0, 1, c_f, "slti_fetch");
        step(0, c_slti, 6'd0, 1, c_d, "slti_decode");
`ifdef MIPS_CTRL_IMM_EN
        step(0, c_slti, 6'd0, 1, c_ix,  "slti_ex");
        step(0, c_slti, 6'd0, 1, c_iwb, "slti_wb");
`endif
        // reset abandoning an R-type in execute
        step(0, c_rt, 6'b100000, 1, c_f,  "add_fetch");
        step(0, c_rt, 6'b100000, 1, c_d,  "add_decode");
        step(1, c_rt, 6'b100000, 1, c_rx, "add_reset");
        step(0, c_rt, 6'b100000, 1, c_f,  "post_reset_fetch");
        step(0, c_rt, 6'b100000, 1, c_d,  "post_reset_decode");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
